// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jogo_pkg
// Description : Shared constants for the memory game: FSM state codes,
//               default per-move timeout and number of rounds.
// Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

  // State codes, also shown on the hex display through db_estado
  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARA     = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARA     = 4'h5;
  localparam logic [3:0] PROX_JOG    = 4'h6;
  localparam logic [3:0] PROX_ROD    = 4'h7;
  localparam logic [3:0] FIM_ACERTO  = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] FIM_ERRO    = 4'hE;

  // Clocks allowed between entering ESPERA and a button press
  localparam int TIMEOUT_CYCLES_PADRAO = 5000;

  // Rounds in a full game (rodada counter runs 0..15)
  localparam int NUM_RODADAS = 16;

endpackage
`default_nettype wire

// File: rtl/unidade_controle_jogo_rodadas_contador_timeout.sv
`default_nettype none
// ============================================================================
// Module      : contador_timeout
// Description : Per-move timeout counter. Counts while enabled, clears
//               synchronously whenever disabled, flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic fim
);

  localparam logic [TW-1:0] C_ULTIMO = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_contagem;

  // Count while waiting for a move; any other state restarts from zero
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_contagem <= '0;
    end else begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  // Gated by enable so a stale count can never raise fim outside ESPERA
  assign fim = enable && (r_contagem == C_ULTIMO);

endmodule
`default_nettype wire

// File: rtl/unidade_controle_jogo_rodadas.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_jogo_rodadas
// Description : Control unit for the memory game. Sequences rounds, detects
//               button press edges, owns the per-move timeout and drives the
//               datapath enables and game status outputs (all Moore).
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_jogo_rodadas
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_PADRAO,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       jogada_correta,
  input  logic       endereco_igual,
  input  logic       fim_rodadas,
  output logic       zera_jogada,
  output logic       conta_jogada,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       registra_jogada,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  logic [3:0] r_estado;
  logic [3:0] w_proximo;
  logic       r_tem_jogada_ant;
  logic       w_borda;
  logic       w_fim_timeout;

  // Previous sample of tem_jogada; a button held across ESPERA entry has
  // this already set, so it cannot produce an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tem_jogada_ant <= 1'b0;
    end else begin
      r_tem_jogada_ant <= tem_jogada;
    end
  end

  assign w_borda = tem_jogada && !r_tem_jogada_ant;

  contador_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_contador_timeout (
    .clock  (clock),
    .reset  (reset),
    .enable (r_estado == ESPERA),
    .fim    (w_fim_timeout)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Next-state logic; in ESPERA a press edge takes priority over the timeout
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      INICIAL:  if (jogar) w_proximo = PREPARA;
      PREPARA:  w_proximo = ESPERA;
      ESPERA: begin
        if (w_borda) begin
          w_proximo = REGISTRA;
        end else if (w_fim_timeout) begin
          w_proximo = FIM_TIMEOUT;
        end
      end
      REGISTRA: w_proximo = COMPARA;
      COMPARA: begin
        if (!jogada_correta) begin
          w_proximo = FIM_ERRO;
        end else if (!endereco_igual) begin
          w_proximo = PROX_JOG;
        end else if (fim_rodadas) begin
          w_proximo = FIM_ACERTO;
        end else begin
          w_proximo = PROX_ROD;
        end
      end
      PROX_JOG: w_proximo = ESPERA;
      PROX_ROD: w_proximo = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (jogar) w_proximo = PREPARA;
      end
      default:  w_proximo = INICIAL;
    endcase
  end

  // Moore outputs decoded from the registered state only
  always_comb begin
    zera_jogada     = (r_estado == PREPARA) || (r_estado == PROX_ROD);
    zera_rodada     = (r_estado == PREPARA);
    conta_jogada    = (r_estado == PROX_JOG);
    conta_rodada    = (r_estado == PROX_ROD);
    registra_jogada = (r_estado == REGISTRA);
    ganhou          = (r_estado == FIM_ACERTO);
    perdeu          = (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
    db_timeout      = (r_estado == FIM_TIMEOUT);
    pronto          = ganhou || perdeu;
    db_estado       = r_estado;
  end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_jogo_rodadas.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_jogo_rodadas
// Description : Directed self-checking bench for the memory game control unit
//               with a 20-cycle move timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_jogo_rodadas;

  logic       clock = 1'b0;
  logic       reset, jogar, tem_jogada, jogada_correta, endereco_igual, fim_rodadas;
  logic       zera_jogada, conta_jogada, zera_rodada, conta_rodada, registra_jogada;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;
  logic [8:0] sinais;

  int checks = 0;
  int errors = 0;

  unidade_controle_jogo_rodadas #(
    .TIMEOUT_CYCLES (20),
    .TW             (5)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .jogar           (jogar),
    .tem_jogada      (tem_jogada),
    .jogada_correta  (jogada_correta),
    .endereco_igual  (endereco_igual),
    .fim_rodadas     (fim_rodadas),
    .zera_jogada     (zera_jogada),
    .conta_jogada    (conta_jogada),
    .zera_rodada     (zera_rodada),
    .conta_rodada    (conta_rodada),
    .registra_jogada (registra_jogada),
    .pronto          (pronto),
    .ganhou          (ganhou),
    .perdeu          (perdeu),
    .db_timeout      (db_timeout),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  // Order: zera_jogada conta_jogada zera_rodada conta_rodada registra_jogada
  //        pronto ganhou perdeu db_timeout
  assign sinais = {zera_jogada, conta_jogada, zera_rodada, conta_rodada,
                   registra_jogada, pronto, ganhou, perdeu, db_timeout};

  // Inputs change just after a falling edge; outputs are read there as well
  task automatic passo();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    passo();
    checks++;
    if (db_estado !== 4'h0 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL reset: estado=%h sinais=%b, esperado estado=0 sinais=000000000", db_estado, sinais);
    end
    reset = 1'b0;
    passo();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle: estado=%h, esperado 0", db_estado);
    end
  endtask

  task automatic test_inicio();
    jogar = 1'b1;
    passo();
    checks++;
    if (db_estado !== 4'h1 || sinais !== 9'b101000000) begin
      errors++;
      $display("FAIL prepara: estado=%h sinais=%b, esperado estado=1 sinais=101000000", db_estado, sinais);
    end
    jogar = 1'b0;
    passo();
    checks++;
    if (db_estado !== 4'h2 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL espera: estado=%h sinais=%b, esperado estado=2 sinais=000000000", db_estado, sinais);
    end
  endtask

  task automatic test_prox_jogada();
    jogada_correta = 1'b1; endereco_igual = 1'b0; fim_rodadas = 1'b0;
    tem_jogada = 1'b1;
    passo();
    checks++;
    if (db_estado !== 4'h4 || sinais !== 9'b000010000) begin
      errors++;
      $display("FAIL registra: estado=%h sinais=%b, esperado estado=4 sinais=000010000", db_estado, sinais);
    end
    passo();
    checks++;
    if (db_estado !== 4'h5 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL compara: estado=%h sinais=%b, esperado estado=5 sinais=000000000", db_estado, sinais);
    end
    passo();
    checks++;
    if (db_estado !== 4'h6 || sinais !== 9'b010000000) begin
      errors++;
      $display("FAIL prox_jog: estado=%h sinais=%b, esperado estado=6 sinais=010000000", db_estado, sinais);
    end
    passo();
    checks++;
    if (db_estado !== 4'h2 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL volta_espera: estado=%h sinais=%b, esperado estado=2 sinais=000000000", db_estado, sinais);
    end
    // Button still held: must not start a second move
    for (int i = 0; i < 4; i++) begin
      passo();
      checks++;
      if (db_estado !== 4'h2) begin
        errors++;
        $display("FAIL botao_segurado[%0d]: estado=%h, esperado 2", i, db_estado);
      end
    end
    tem_jogada = 1'b0;
    passo();
  endtask

  task automatic test_prox_rodada_e_acerto();
    jogada_correta = 1'b1; endereco_igual = 1'b1; fim_rodadas = 1'b0;
    tem_jogada = 1'b1;
    passo();
    tem_jogada = 1'b0;
    passo();
    passo();
    checks++;
    if (db_estado !== 4'h7 || sinais !== 9'b100100000) begin
      errors++;
      $display("FAIL prox_rod: estado=%h sinais=%b, esperado estado=7 sinais=100100000", db_estado, sinais);
    end
    passo();
    checks++;
    if (db_estado !== 4'h2 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL prox_rod_espera: estado=%h sinais=%b, esperado estado=2 sinais=000000000", db_estado, sinais);
    end
    fim_rodadas = 1'b1;
    tem_jogada = 1'b1;
    passo();
    tem_jogada = 1'b0;
    passo();
    passo();
    checks++;
    if (db_estado !== 4'hA || sinais !== 9'b000001100) begin
      errors++;
      $display("FAIL acerto: estado=%h sinais=%b, esperado estado=A sinais=000001100", db_estado, sinais);
    end
    for (int i = 0; i < 30; i++) passo();
    checks++;
    if (db_estado !== 4'hA || sinais !== 9'b000001100) begin
      errors++;
      $display("FAIL acerto_mantido: estado=%h sinais=%b, esperado estado=A sinais=000001100", db_estado, sinais);
    end
    fim_rodadas = 1'b0;
  endtask

  task automatic test_erro();
    jogar = 1'b1;
    passo();
    jogar = 1'b0;
    passo();
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL reinicio_acerto: estado=%h, esperado 2", db_estado);
    end
    jogada_correta = 1'b0; endereco_igual = 1'b0;
    tem_jogada = 1'b1;
    passo();
    tem_jogada = 1'b0;
    passo();
    passo();
    checks++;
    if (db_estado !== 4'hE || sinais !== 9'b000001010) begin
      errors++;
      $display("FAIL erro: estado=%h sinais=%b, esperado estado=E sinais=000001010", db_estado, sinais);
    end
    jogar = 1'b1;
    passo();
    checks++;
    if (db_estado !== 4'h1 || sinais !== 9'b101000000) begin
      errors++;
      $display("FAIL erro_prepara: estado=%h sinais=%b, esperado estado=1 sinais=101000000", db_estado, sinais);
    end
    jogar = 1'b0;
    passo();
  endtask

  task automatic test_timeout();
    // Just entered ESPERA: 19 more clocks still waiting, the 20th times out
    for (int i = 0; i < 19; i++) passo();
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL timeout_cedo: estado=%h, esperado 2", db_estado);
    end
    passo();
    checks++;
    if (db_estado !== 4'hD || sinais !== 9'b000001011) begin
      errors++;
      $display("FAIL timeout: estado=%h sinais=%b, esperado estado=D sinais=000001011", db_estado, sinais);
    end
    // Press landing on the 20th clock wins over the timeout
    jogar = 1'b1;
    passo();
    jogar = 1'b0;
    passo();
    for (int i = 0; i < 19; i++) passo();
    jogada_correta = 1'b1; endereco_igual = 1'b0;
    tem_jogada = 1'b1;
    passo();
    checks++;
    if (db_estado !== 4'h4 || sinais !== 9'b000010000) begin
      errors++;
      $display("FAIL borda_no_limite: estado=%h sinais=%b, esperado estado=4 sinais=000010000", db_estado, sinais);
    end
    tem_jogada = 1'b0;
    passo();
    passo();
    passo();
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL borda_limite_volta: estado=%h, esperado 2", db_estado);
    end
  endtask

  task automatic test_reset_meio_jogo();
    // Reset during COMPARA
    tem_jogada = 1'b1;
    passo();
    tem_jogada = 1'b0;
    passo();
    checks++;
    if (db_estado !== 4'h5) begin
      errors++;
      $display("FAIL antes_reset_compara: estado=%h, esperado 5", db_estado);
    end
    reset = 1'b1;
    passo();
    reset = 1'b0;
    checks++;
    if (db_estado !== 4'h0 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL reset_compara: estado=%h sinais=%b, esperado estado=0 sinais=000000000", db_estado, sinais);
    end
    // jogar ignored while in ESPERA
    jogar = 1'b1;
    passo();
    jogar = 1'b0;
    passo();
    jogar = 1'b1;
    passo();
    jogar = 1'b0;
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL jogar_em_espera: estado=%h, esperado 2", db_estado);
    end
    // Reach FIM_ACERTO, then reset there
    endereco_igual = 1'b1; fim_rodadas = 1'b1;
    tem_jogada = 1'b1;
    passo();
    tem_jogada = 1'b0;
    passo();
    passo();
    checks++;
    if (db_estado !== 4'hA) begin
      errors++;
      $display("FAIL antes_reset_acerto: estado=%h, esperado A", db_estado);
    end
    reset = 1'b1;
    passo();
    reset = 1'b0;
    checks++;
    if (db_estado !== 4'h0 || sinais !== 9'b000000000) begin
      errors++;
      $display("FAIL reset_acerto: estado=%h sinais=%b, esperado estado=0 sinais=000000000", db_estado, sinais);
    end
    fim_rodadas = 1'b0; endereco_igual = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; tem_jogada = 1'b0;
    jogada_correta = 1'b0; endereco_igual = 1'b0; fim_rodadas = 1'b0;
    test_reset();
    test_inicio();
    test_prox_jogada();
    test_prox_rodada_e_acerto();
    test_erro();
    test_timeout();
    test_reset_meio_jogo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
